// File: rtl/cache_page_ctrl_pkg.sv
// Shared types for the cache page controller.
// Owner-table entry and allocation FSM state.
package cache_pkg;

  localparam int CLI_MAXW = 8;

  typedef logic [CLI_MAXW-1:0] cli_t;

  typedef struct packed {
    logic valid;
    cli_t cli;
  } owner_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } alloc_st_e;

endpackage

// File: rtl/cache_page_if.sv
// Client-side bus of the page controller.
// master = client agents, slave = controller.
interface cache_page_if #(
  parameter int NCLI   = 4,
  parameter int AWIDTH = 5
);
  logic [NCLI-1:0]        cli_req;
  logic [NCLI-1:0]        cli_gnt;
  logic [NCLI-1:0]        cli_nak;
  logic [AWIDTH-1:0]      cli_page_id;
  logic [NCLI-1:0]        cli_rel;
  logic [NCLI*AWIDTH-1:0] cli_rel_id;
  logic [NCLI-1:0]        cli_rel_ack;
  logic                   rel_err;

  modport master (
    output cli_req, cli_rel, cli_rel_id,
    input  cli_gnt, cli_nak, cli_page_id,
    input  cli_rel_ack, rel_err
  );

  modport slave (
    input  cli_req, cli_rel, cli_rel_id,
    output cli_gnt, cli_nak, cli_page_id,
    output cli_rel_ack, rel_err
  );
endinterface

// File: rtl/cache_page_ctrl_rr_arbiter.sv
// Round-robin arbiter: first request at or after ptr.
// Gives onehot grant, index and any-request flag.
module rr_arbiter #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  // scan from ptr, wrapping, keep the first hit
  always_comb begin
    int c;
    c     = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      c = (int'(ptr_i) + i) % N;
      if (!any_o && req_i[c]) begin
        any_o    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = W'(c);
      end
    end
  end

endmodule

// File: rtl/cache_page_ctrl.sv
// Shares one page allocator among NCLI clients.
// RR alloc + RR release, owner table, occupancy.
module cache_page_ctrl
  import cache_pkg::*;
#(
  parameter  int NCLI   = 4,
  parameter  int PAGES  = 32,
  localparam int AWIDTH = $clog2(PAGES),
  localparam int CWIDTH = $clog2(NCLI)
) (
  input  logic              clk,
  input  logic              rst,
  cache_page_if.slave       cif,
  output logic              page_req,
  output logic              page_clr,
  output logic [AWIDTH-1:0] page_id_clr,
  input  logic [AWIDTH-1:0] page_id,
  input  logic              page_grant,
  output logic [AWIDTH:0]   used_cnt
);

  alloc_st_e         st_q, st_d;
  logic [CWIDTH-1:0] cur_q, cur_d;
  logic [NCLI-1:0]   cur_oh_q, cur_oh_d;
  logic [CWIDTH-1:0] aptr_q, aptr_d;
  logic [CWIDTH-1:0] rptr_q, rptr_d;
  logic              preq_q, preq_d;
  logic [NCLI-1:0]   gnt_q, gnt_d;
  logic [NCLI-1:0]   nak_q, nak_d;
  logic [AWIDTH-1:0] pid_q, pid_d;
  logic [NCLI-1:0]   ack_q, ack_d;
  logic              err_q, err_d;
  logic              clr_q, clr_d;
  logic [AWIDTH-1:0] clr_id_q, clr_id_d;
  logic [AWIDTH:0]   cnt_q, cnt_d;
  owner_t            own_q [PAGES];

  logic [NCLI-1:0]   a_req, a_gnt;
  logic [CWIDTH-1:0] a_idx;
  logic              a_any;
  logic [NCLI-1:0]   r_req, r_gnt;
  logic [CWIDTH-1:0] r_idx;
  logic              r_any;
  logic [AWIDTH-1:0] rel_id;
  owner_t            rel_own;
  logic              rel_ok;
  logic              grant_ev;

  // a client just answered is not re-picked that cycle
  assign a_req = cif.cli_req & ~gnt_q & ~nak_q;
  assign r_req = cif.cli_rel & ~ack_q;

  rr_arbiter #(.N(NCLI)) u_alloc_arb (
    .req_i (a_req),
    .ptr_i (aptr_q),
    .gnt_o (a_gnt),
    .idx_o (a_idx),
    .any_o (a_any)
  );

  rr_arbiter #(.N(NCLI)) u_rel_arb (
    .req_i (r_req),
    .ptr_i (rptr_q),
    .gnt_o (r_gnt),
    .idx_o (r_idx),
    .any_o (r_any)
  );

  // alloc FSM: WAIT spans the page_req cycle and the grant cycle
  always_comb begin
    st_d     = st_q;
    cur_d    = cur_q;
    cur_oh_d = cur_oh_q;
    aptr_d   = aptr_q;
    preq_d   = 1'b0;
    gnt_d    = '0;
    nak_d    = '0;
    pid_d    = pid_q;
    grant_ev = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (a_any) begin
          cur_d    = a_idx;
          cur_oh_d = a_gnt;
          preq_d   = 1'b1;
          st_d     = WAIT;
        end
      end
      WAIT: begin
        if (!preq_q) begin
          if (page_grant) begin
            gnt_d    = cur_oh_q;
            pid_d    = page_id;
            grant_ev = 1'b1;
          end else begin
            nak_d = cur_oh_q;
          end
          aptr_d = (cur_q == CWIDTH'(NCLI - 1)) ?
                   '0 : cur_q + 1'b1;
          st_d   = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  // release: legality from the table as it stands now
  always_comb begin
    rel_id   = cif.cli_rel_id[int'(r_idx)*AWIDTH +: AWIDTH];
    rel_own  = own_q[rel_id];
    rel_ok   = r_any && rel_own.valid &&
               (rel_own.cli == cli_t'(r_idx));
    ack_d    = r_any ? r_gnt : '0;
    err_d    = r_any && !rel_ok;
    clr_d    = rel_ok;
    clr_id_d = rel_ok ? rel_id : '0;
    rptr_d   = rptr_q;
    if (r_any)
      rptr_d = (r_idx == CWIDTH'(NCLI - 1)) ?
               '0 : r_idx + 1'b1;
  end

  // occupancy: grant and release in one cycle cancel
  always_comb begin
    cnt_d = cnt_q;
    unique case ({grant_ev, rel_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= IDLE;
      cur_q    <= '0;
      cur_oh_q <= '0;
      aptr_q   <= '0;
      rptr_q   <= '0;
      preq_q   <= 1'b0;
      gnt_q    <= '0;
      nak_q    <= '0;
      pid_q    <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
      clr_q    <= 1'b0;
      clr_id_q <= '0;
      cnt_q    <= '0;
    end else begin
      st_q     <= st_d;
      cur_q    <= cur_d;
      cur_oh_q <= cur_oh_d;
      aptr_q   <= aptr_d;
      rptr_q   <= rptr_d;
      preq_q   <= preq_d;
      gnt_q    <= gnt_d;
      nak_q    <= nak_d;
      pid_q    <= pid_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      clr_q    <= clr_d;
      clr_id_q <= clr_id_d;
      cnt_q    <= cnt_d;
    end
  end

  // owner table: grant write lands after the release clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PAGES; i++)
        own_q[i] <= '0;
    end else begin
      if (rel_ok)
        own_q[rel_id].valid <= 1'b0;
      if (grant_ev)
        own_q[page_id] <= '{valid: 1'b1,
                            cli: cli_t'(cur_q)};
    end
  end

  assign page_req        = preq_q;
  assign page_clr        = clr_q;
  assign page_id_clr     = clr_id_q;
  assign used_cnt        = cnt_q;
  assign cif.cli_gnt     = gnt_q;
  assign cif.cli_nak     = nak_q;
  assign cif.cli_page_id = pid_q;
  assign cif.cli_rel_ack = ack_q;
  assign cif.rel_err     = err_q;

endmodule

// File: tb/tb_cache_page_ctrl.sv
// Directed bench for cache_page_ctrl.
// Includes a lowest-free-first allocator model.
module tb_cache_page_ctrl;

  localparam int NCLI  = 4;
  localparam int PAGES = 32;
  localparam int AW    = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_page_if #(.NCLI(NCLI), .AWIDTH(AW)) cif();

  logic          page_req, page_clr, page_grant;
  logic [AW-1:0] page_id_clr, page_id;
  logic [AW:0]   used_cnt;

  cache_page_ctrl #(.NCLI(NCLI), .PAGES(PAGES)) dut (
    .clk         (clk),
    .rst         (rst),
    .cif         (cif),
    .page_req    (page_req),
    .page_clr    (page_clr),
    .page_id_clr (page_id_clr),
    .page_id     (page_id),
    .page_grant  (page_grant),
    .used_cnt    (used_cnt)
  );

  int tests = 0;
  int fails = 0;

  // allocator model: lowest free page, grant registered
  logic [PAGES-1:0] busy;

  function automatic int first_free(logic [PAGES-1:0] b);
    for (int i = 0; i < PAGES; i++)
      if (!b[i]) return i;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= '0;
      page_grant <= 1'b0;
      page_id    <= '0;
    end else begin
      page_grant <= 1'b0;
      if (page_req && first_free(busy) >= 0) begin
        page_grant             <= 1'b1;
        page_id                <= AW'(first_free(busy));
        busy[first_free(busy)] <= 1'b1;
      end
      if (page_clr) busy[page_id_clr] <= 1'b0;
    end
  end

  int cyc = 0;
  int clr_seen = 0;
  int resp_seen = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (page_clr) clr_seen <= clr_seen + 1;
    if (|cif.cli_gnt || |cif.cli_nak)
      resp_seen <= resp_seen + 1;
  end

  task automatic wait_resp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      @(negedge clk);
      if (|cif.cli_gnt || |cif.cli_nak) ok = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cif.cli_req = '0;
    cif.cli_rel = '0;
    cif.cli_rel_id = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if ({page_req, page_clr, page_id_clr, used_cnt,
         cif.cli_gnt, cif.cli_nak, cif.cli_page_id,
         cif.cli_rel_ack, cif.rel_err} !== '0) begin
      fails++;
      $display("FAIL reset_outs: got used=%0d req=%b gnt=%b exp all 0",
               used_cnt, page_req, cif.cli_gnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    cif.cli_req = 4'b0001;
    @(negedge clk);
    tests++;
    if (page_req !== 1'b1) begin
      fails++;
      $display("FAIL single_preq_t1: got %b exp 1", page_req);
    end
    @(negedge clk);
    tests++;
    if (page_req !== 1'b0 || cif.cli_gnt !== 4'b0) begin
      fails++;
      $display("FAIL single_t2: got preq=%b gnt=%b exp 0/0000",
               page_req, cif.cli_gnt);
    end
    @(negedge clk);
    cif.cli_req = '0;
    tests++;
    if (cif.cli_gnt !== 4'b0001 || cif.cli_page_id !== 5'd0 ||
        used_cnt !== 6'd1) begin
      fails++;
      $display("FAIL single_gnt_t3: got gnt=%b id=%0d used=%0d exp 0001/0/1",
               cif.cli_gnt, cif.cli_page_id, used_cnt);
    end
    @(negedge clk);
    tests++;
    if (cif.cli_gnt !== 4'b0) begin
      fails++;
      $display("FAIL single_pulse: got gnt=%b exp 0000", cif.cli_gnt);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int last;
    do_reset();
    last = 0;
    cif.cli_req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_resp(ok);
      if (k == 3) cif.cli_req = '0;
      tests++;
      if (!ok || cif.cli_gnt !== 4'(1 << k) ||
          cif.cli_page_id !== AW'(k)) begin
        fails++;
        $display("FAIL rr_grant%0d: got ok=%0b gnt=%b id=%0d exp gnt=%b id=%0d",
                 k, ok, cif.cli_gnt, cif.cli_page_id, 4'(1 << k), k);
      end
      if (k > 0) begin
        tests++;
        if (cyc - last !== 3) begin
          fails++;
          $display("FAIL rr_spacing%0d: got %0d cycles exp 3",
                   k, cyc - last);
        end
      end
      last = cyc;
    end
    repeat (4) @(negedge clk);
    tests++;
    if (used_cnt !== 6'd4) begin
      fails++;
      $display("FAIL rr_used: got %0d exp 4", used_cnt);
    end
  endtask

  task automatic test_full();
    bit ok;
    int bad;
    int clr0;
    do_reset();
    bad = 0;
    clr0 = clr_seen;
    cif.cli_req = 4'b0001;
    for (int k = 0; k < PAGES; k++) begin
      wait_resp(ok);
      if (!ok || cif.cli_gnt !== 4'b0001 ||
          cif.cli_page_id !== AW'(k)) bad++;
    end
    cif.cli_req = '0;
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL full_fill: got %0d bad grants exp 0", bad);
    end
    @(negedge clk);
    cif.cli_req = 4'b0100;
    repeat (3) @(negedge clk);
    cif.cli_req = '0;
    tests++;
    if (cif.cli_nak !== 4'b0100 || cif.cli_gnt !== 4'b0 ||
        used_cnt !== 6'd32) begin
      fails++;
      $display("FAIL full_nak: got nak=%b gnt=%b used=%0d exp 0100/0000/32",
               cif.cli_nak, cif.cli_gnt, used_cnt);
    end
    @(negedge clk);
    tests++;
    if (clr_seen - clr0 !== 0) begin
      fails++;
      $display("FAIL full_noclr: got %0d clears exp 0",
               clr_seen - clr0);
    end
  endtask

  task automatic test_release();
    bit ok;
    do_reset();
    cif.cli_req = 4'b0001;
    for (int k = 0; k < 5; k++) wait_resp(ok);
    cif.cli_req = 4'b0010;
    wait_resp(ok);
    cif.cli_req = '0;
    tests++;
    if (!ok || cif.cli_gnt !== 4'b0010 ||
        cif.cli_page_id !== 5'd5) begin
      fails++;
      $display("FAIL rel_setup: got gnt=%b id=%0d exp 0010/5",
               cif.cli_gnt, cif.cli_page_id);
    end
    @(negedge clk);
    cif.cli_rel_id[1*AW +: AW] = 5'd5;
    cif.cli_rel = 4'b0010;
    @(negedge clk);
    cif.cli_rel = '0;
    tests++;
    if (page_clr !== 1'b1 || page_id_clr !== 5'd5 ||
        cif.cli_rel_ack !== 4'b0010 || cif.rel_err !== 1'b0 ||
        used_cnt !== 6'd5) begin
      fails++;
      $display("FAIL rel_legal: got clr=%b id=%0d ack=%b err=%b used=%0d exp 1/5/0010/0/5",
               page_clr, page_id_clr, cif.cli_rel_ack,
               cif.rel_err, used_cnt);
    end
    @(negedge clk);
    tests++;
    if (page_clr !== 1'b0 || cif.cli_rel_ack !== 4'b0) begin
      fails++;
      $display("FAIL rel_pulse: got clr=%b ack=%b exp 0/0000",
               page_clr, cif.cli_rel_ack);
    end
    cif.cli_rel_id[3*AW +: AW] = 5'd0;
    cif.cli_rel = 4'b1000;
    @(negedge clk);
    cif.cli_rel = '0;
    tests++;
    if (cif.cli_rel_ack !== 4'b1000 || cif.rel_err !== 1'b1 ||
        page_clr !== 1'b0 || used_cnt !== 6'd5) begin
      fails++;
      $display("FAIL rel_foreign: got ack=%b err=%b clr=%b used=%0d exp 1000/1/0/5",
               cif.cli_rel_ack, cif.rel_err, page_clr, used_cnt);
    end
    @(negedge clk);
    cif.cli_rel_id[3*AW +: AW] = 5'd5;
    cif.cli_rel = 4'b1000;
    @(negedge clk);
    cif.cli_rel = '0;
    tests++;
    if (cif.cli_rel_ack !== 4'b1000 || cif.rel_err !== 1'b1 ||
        page_clr !== 1'b0 || used_cnt !== 6'd5) begin
      fails++;
      $display("FAIL rel_unowned: got ack=%b err=%b clr=%b used=%0d exp 1000/1/0/5",
               cif.cli_rel_ack, cif.rel_err, page_clr, used_cnt);
    end
  endtask

  task automatic test_concurrent();
    bit ok;
    do_reset();
    cif.cli_req = 4'b0001;
    wait_resp(ok);
    cif.cli_req = '0;
    @(negedge clk);
    cif.cli_req = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    cif.cli_rel_id[0 +: AW] = 5'd0;
    cif.cli_rel = 4'b0001;
    @(negedge clk);
    cif.cli_req = '0;
    cif.cli_rel = '0;
    tests++;
    if (cif.cli_gnt !== 4'b0100 || cif.cli_page_id !== 5'd1 ||
        cif.cli_rel_ack !== 4'b0001 || page_clr !== 1'b1 ||
        page_id_clr !== 5'd0 || used_cnt !== 6'd1) begin
      fails++;
      $display("FAIL conc_both: got gnt=%b id=%0d ack=%b clr=%b cid=%0d used=%0d exp 0100/1/0001/1/0/1",
               cif.cli_gnt, cif.cli_page_id, cif.cli_rel_ack,
               page_clr, page_id_clr, used_cnt);
    end
    @(negedge clk);
    cif.cli_req = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    cif.cli_rel_id[1*AW +: AW] = 5'd0;
    cif.cli_rel = 4'b0010;
    @(negedge clk);
    cif.cli_req = '0;
    cif.cli_rel = '0;
    tests++;
    if (cif.cli_gnt !== 4'b0010 || cif.cli_page_id !== 5'd0 ||
        cif.cli_rel_ack !== 4'b0010 || cif.rel_err !== 1'b1 ||
        page_clr !== 1'b0 || used_cnt !== 6'd2) begin
      fails++;
      $display("FAIL conc_early_rel: got gnt=%b id=%0d ack=%b err=%b clr=%b used=%0d exp 0010/0/0010/1/0/2",
               cif.cli_gnt, cif.cli_page_id, cif.cli_rel_ack,
               cif.rel_err, page_clr, used_cnt);
    end
    @(negedge clk);
    cif.cli_rel = 4'b0010;
    @(negedge clk);
    cif.cli_rel = '0;
    tests++;
    if (page_clr !== 1'b1 || page_id_clr !== 5'd0 ||
        cif.rel_err !== 1'b0 || used_cnt !== 6'd1) begin
      fails++;
      $display("FAIL conc_late_rel: got clr=%b id=%0d err=%b used=%0d exp 1/0/0/1",
               page_clr, page_id_clr, cif.rel_err, used_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int r0;
    do_reset();
    cif.cli_req = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    cif.cli_req = '0;
    @(negedge clk);
    tests++;
    if ({page_req, page_clr, used_cnt, cif.cli_gnt,
         cif.cli_nak, cif.cli_rel_ack, cif.rel_err} !== '0) begin
      fails++;
      $display("FAIL midrst_outs: got used=%0d gnt=%b nak=%b exp 0",
               used_cnt, cif.cli_gnt, cif.cli_nak);
    end
    rst = 1'b0;
    r0 = resp_seen;
    repeat (6) @(negedge clk);
    tests++;
    if (resp_seen - r0 !== 0 || used_cnt !== 6'd0) begin
      fails++;
      $display("FAIL midrst_noresp: got resp=%0d used=%0d exp 0/0",
               resp_seen - r0, used_cnt);
    end
  endtask

  initial begin
    cif.cli_req = '0;
    cif.cli_rel = '0;
    cif.cli_rel_id = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_release();
    test_concurrent();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
